flopr_pipe: RTL and testbench

- Parametrised successor to the single flopr register: a DEPTH-stage elastic pipeline register of N-bit words.
- Uses a valid/ready handshake on both sides, collapses bubbles, supports a synchronous flush, and reports occupancy.
- Placed between processor pipeline stages and on multicycle datapaths where the downstream consumer can stall.

---
 rtl/flopr_pkg.sv | 15 +
 rtl/flopr_stage.sv | 56 +++++
 rtl/flopr_pipe.sv | 103 ++++++++++
 tb/tb_flopr_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flopr_pkg.sv
// Shared definitions for the flopr pipeline register family.
//   WORD_W : default data word width
//   word_t : default-width data word
//   cnt_w  : width of an occupancy counter able to hold 0..depth
package flopr_pkg;

    localparam int unsigned WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flopr_stage.sv
// One pipeline stage: N-bit data register plus valid bit.
//   clk       : clock, all updates on posedge
//   reset     : synchronous active-high reset (valid and data to 0)
//   clr       : synchronous clear (valid and data to 0)
//   load      : stage accepts valid_in/d this cycle
//   valid_in  : incoming valid bit
//   d         : incoming data word
//   valid_out : stage holds a valid word
//   q         : stage data register
module flopr_stage
    import flopr_pkg::*;
#(
    parameter int unsigned N = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         valid_in,
    input  logic [N-1:0] d,
    output logic         valid_out,
    output logic [N-1:0] q
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            // A bubble clears valid but leaves the old data in place.
            valid_d = valid_in;
            if (valid_in) begin
                data_d = d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign q         = data_q;

endmodule

// File: rtl/flopr_pipe.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake,
// bubble collapse, synchronous flush and occupancy count.
//   clk       : clock, all updates on posedge
//   reset     : synchronous active-high reset, wins over flush
//   flush     : synchronous clear of all in-flight words
//   in_valid  : upstream presents a word on d
//   in_ready  : pipeline accepts a word this cycle
//   d         : input data word
//   out_valid : q holds a valid word
//   out_ready : downstream accepts q this cycle
//   q         : output data word (last stage)
//   count     : number of valid words held
module flopr_pipe
    import flopr_pkg::*;
#(
    parameter int unsigned N     = WORD_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N-1:0]              q,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] valid;
    logic [N-1:0]     data [DEPTH];
    logic             slot_free;
    logic             in_fire, out_fire;
    logic [CW-1:0]    count_q, count_d;

    // ready[k] = !valid[k] || ready[k+1], unrolled as "downstream ready or
    // any empty stage at or beyond k" so no bit feeds back into the vector.
    always_comb begin
        ready        = '0;
        slot_free    = out_ready;
        ready[DEPTH] = out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_free              = slot_free || !valid[DEPTH-1-i];
            ready[DEPTH-1-i]       = slot_free;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic         v_in;
        logic [N-1:0] d_in;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign d_in = d;
        end else begin : g_body
            assign v_in = valid[k-1];
            assign d_in = data[k-1];
        end

        flopr_stage #(
            .N(N)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .clr       (flush),
            .load      (ready[k]),
            .valid_in  (v_in),
            .d         (d_in),
            .valid_out (valid[k]),
            .q         (data[k])
        );
    end

    assign in_ready  = ready[0] && !reset;
    assign out_valid = valid[DEPTH-1];
    assign q         = data[DEPTH-1];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_fire) - CW'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_flopr_pipe.sv
module tb_flopr_pipe;

    localparam int unsigned DA = 4;
    localparam int unsigned DB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_d, a_q;
    logic [2:0]  a_count;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_d, b_q;
    logic [0:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    flopr_pipe #(.N(64), .DEPTH(DA)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .d(a_d),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .q(a_q),
        .count(a_count)
    );

    flopr_pipe #(.N(32), .DEPTH(DB)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .d(b_d),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .q(b_q),
        .count(b_count)
    );

    // Reference model: per instance, an ordered list of held words (oldest
    // first) with the stage each word currently sits in, plus the data last
    // delivered into the output stage (q keeps it after the word leaves).
    logic [63:0] m_data [2][4];
    int          m_pos  [2][4];
    int          m_size [2];
    logic [63:0] m_last [2];
    int          m_depth [2];

    bit          checking;
    logic        a_fire;
    logic        a_pend, b_pend;
    logic [63:0] a_pend_d;
    logic [31:0] b_pend_d;
    logic [63:0] w3 [6];
    int          idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_in_ready(input int i, input logic rst, input logic ordy);
        return !rst && ((m_size[i] < m_depth[i]) || ordy);
    endfunction

    function automatic bit m_out_valid(input int i);
        return (m_size[i] > 0) && (m_pos[i][0] == m_depth[i] - 1);
    endfunction

    task automatic m_step(input int i, input logic rst, input logic fl, input logic iv,
                          input logic [63:0] dd, input logic ordy, output logic fired);
        bit in_fire, out_fire;
        int dep;
        dep      = m_depth[i];
        in_fire  = iv && m_in_ready(i, rst, ordy);
        out_fire = m_out_valid(i) && ordy;
        fired    = in_fire;
        if (rst) begin
            m_size[i] = 0;
            m_last[i] = '0;
            fired     = 1'b0;
            return;
        end
        // A word moves on if downstream takes the head, or if fewer older
        // words are ahead of it than there are stages ahead of it.
        for (int j = 0; j < m_size[i]; j++) begin
            if (m_pos[i][j] < dep - 1 && (ordy || j < dep - 1 - m_pos[i][j])) begin
                m_pos[i][j]++;
                if (m_pos[i][j] == dep - 1) m_last[i] = m_data[i][j];
            end
        end
        if (out_fire) begin
            for (int j = 0; j < 3; j++) begin
                m_data[i][j] = m_data[i][j+1];
                m_pos[i][j]  = m_pos[i][j+1];
            end
            m_size[i]--;
        end
        if (in_fire && !fl) begin
            m_data[i][m_size[i]] = dd;
            m_pos[i][m_size[i]]  = 0;
            m_size[i]++;
            if (dep == 1) m_last[i] = dd;
        end
        if (fl) begin
            m_size[i] = 0;
            m_last[i] = '0;
        end
    endtask

    // One clock: drive B randomly, compare both DUTs with the model, advance
    // the model across the posedge, and return at the following negedge.
    task automatic tick();
        logic af, bf;
        b_in_valid  = b_pend;
        b_d         = b_pend_d;
        b_out_ready = ($urandom_range(3) != 0);
        #1;
        if (checking) begin
            check("a_in_ready",  64'(a_in_ready),  64'(m_in_ready(0, reset, a_out_ready)));
            check("a_out_valid", 64'(a_out_valid), 64'(m_out_valid(0)));
            check("a_q",         a_q,              m_last[0]);
            check("a_count",     64'(a_count),     64'(m_size[0]));
            check("b_in_ready",  64'(b_in_ready),  64'(m_in_ready(1, reset, b_out_ready)));
            check("b_out_valid", 64'(b_out_valid), 64'(m_out_valid(1)));
            check("b_q",         64'(b_q),         m_last[1]);
            check("b_count",     64'(b_count),     64'(m_size[1]));
        end
        m_step(0, reset, flush, a_in_valid, a_d, a_out_ready, af);
        m_step(1, reset, flush, b_in_valid, 64'(b_d), b_out_ready, bf);
        a_fire = af;
        @(negedge clk);
        if (bf || flush || reset) b_pend = 1'b0;
        if (!b_pend && $urandom_range(1) == 1) begin
            b_pend   = 1'b1;
            b_pend_d = $urandom;
        end
    endtask

    initial begin
        m_depth[0] = DA;
        m_depth[1] = DB;
        m_size[0]  = 0;
        m_size[1]  = 0;
        m_last[0]  = '0;
        m_last[1]  = '0;
        b_pend     = 1'b0;
        b_pend_d   = '0;
        a_pend     = 1'b0;
        a_pend_d   = '0;
        checking   = 1'b0;

        // Reset with a word offered: nothing accepted.
        reset       = 1'b1;
        flush       = 1'b0;
        a_in_valid  = 1'b1;
        a_d         = 64'hc4c4;
        a_out_ready = 1'b1;
        tick();
        checking = 1'b1;
        tick();
        check("rst_in_ready_low", 64'(a_in_ready), 64'd0);
        reset      = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
        tick();

        // Streaming with downstream always ready.
        w3[0] = 64'hcec1; w3[1] = 64'hcac1; w3[2] = 64'hc0c0;
        w3[3] = 64'hcafe; w3[4] = 64'hdad0; w3[5] = 64'h1234_5678_9abc_def0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_d        = w3[i];
            tick();
            if (i == 3) begin
                check("s2_first_out", a_q, 64'hcec1);
                check("s2_count_peak", 64'(a_count), 64'd4);
            end
        end
        a_in_valid = 1'b0;
        repeat (6) tick();

        // Backpressure: fill, hold, then release.
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a_out_ready = (cyc >= 8);
            a_in_valid  = (idx < 6);
            a_d         = w3[(idx < 6) ? idx : 0];
            tick();
            if (a_fire) idx++;
            if (cyc == 7) begin
                check("s3_count_full", 64'(a_count), 64'd4);
                check("s3_in_ready_low", 64'(a_in_ready), 64'd0);
                check("s3_q_stable", a_q, w3[0]);
            end
        end
        check("s3_all_accepted", 64'(idx), 64'd6);

        // Bubble collapse behind a stalled word.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_d         = 64'hcafe;
        tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        a_in_valid = 1'b1;
        a_d        = 64'hdad0;
        tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        check("s4_count", 64'(a_count), 64'd2);
        check("s4_q_head", a_q, 64'hcafe);
        a_out_ready = 1'b1;
        tick();
        check("s4_q_second", a_q, 64'hdad0);
        repeat (2) tick();

        // Flush with words in flight and a word offered.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_d        = w3[i];
            tick();
        end
        a_d   = 64'hc3c1;
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        a_in_valid = 1'b0;
        check("s5_flush_count", 64'(a_count), 64'd0);
        check("s5_flush_valid", 64'(a_out_valid), 64'd0);
        check("s5_flush_q", a_q, 64'd0);
        a_out_ready = 1'b1;
        repeat (5) tick();

        // Reset together with flush.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_d        = w3[i+2];
            tick();
        end
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset      = 1'b0;
        flush      = 1'b0;
        a_in_valid = 1'b0;
        check("s5_rst_count", 64'(a_count), 64'd0);
        check("s5_rst_q", a_q, 64'd0);
        tick();

        // Random traffic on both instances with occasional flush and reset.
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!a_pend && $urandom_range(2) != 0) begin
                a_pend   = 1'b1;
                a_pend_d = {$urandom, $urandom};
            end
            a_in_valid  = a_pend;
            a_d         = a_pend_d;
            a_out_ready = ($urandom_range(2) != 0);
            flush       = ($urandom_range(49) == 0);
            reset       = ($urandom_range(99) == 0);
            tick();
            if (a_fire || flush || reset) a_pend = 1'b0;
        end
        flush = 1'b0;
        reset = 1'b0;
        a_in_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
